ahblite_gpio_irq: RTL and testbench
===================================

Name: ahblite_gpio_irq

Overview:
- Parametrised next-generation AHB-Lite GPIO peripheral on one interconnect slave port.
- Per-pin direction control, atomic set/clear of output bits, synchronised input sampling, and per-pin rising/falling edge interrupts with write-1-to-clear status.
- The pad-side interface (outEn, oData, iData) drives an external tristate pad wrapper.
- The IRQ output connects to one bit of the core IRQ vector.

Parameters:
- WIDTH, 8, number of GPIO pins (1..32); register bits above WIDTH-1 read 0 and ignore writes.
- SYNC_STAGES, 2, input synchroniser depth (2..4).

Ports:
- HCLK  input  1  clock; all logic on its rising edge.
- HRESETn  input  1  reset, synchronous, active-low.
- HSEL  input  1  slave select.
- HADDR  input  32  address; only HADDR[5:2] decoded.
- HTRANS  input  2  transfer type; HTRANS[1] marks NONSEQ/SEQ.
- HSIZE  input  3  ignored; all accesses treated as word.
- HPROT  input  4  ignored.
- HWRITE  input  1  write strobe.
- HWDATA  input  32  write data, data phase.
- HREADY  input  1  bus ready.
- HREADYOUT  output  1  constant 1 (zero wait states).
- HRESP  output  1  constant 0 (OKAY).
- HRDATA  output  32  read data, data phase.
- outEn  output  WIDTH  per-pin output enable (1 = drive).
- oData  output  WIDTH  output values.
- iData  input  WIDTH  raw pad inputs, asynchronous.
- IRQ  output  1  level interrupt request.

Behaviour:
- Reset: while HRESETn is low at a rising edge, the following all become 0: DOUT, DIR, IRQ_EN, RISE_EN, FALL_EN, STATUS, all synchroniser and previous-sample flops, and the latched address-phase state. As a result oData, outEn, IRQ and HRDATA are 0.
- Address phase: when HSEL & HTRANS[1] & HREADY, latch valid=1, write=HWRITE and idx=HADDR[5:2]; otherwise latch valid=0.
- Data phase write: on the next edge, if valid & write, update register idx from HWDATA[WIDTH-1:0].
- Data phase read: HRDATA is combinational from the latched idx when valid & ~write; otherwise HRDATA is 0.
- Read after write to the same register in the following transfer returns the new value.
- Register map (offset, access, meaning):
  - 0x00 DOUT, RW, drives oData.
  - 0x04 DIR, RW, drives outEn.
  - 0x08 DIN, RO, synchronised input.
  - 0x0C IRQ_EN, RW, per-pin interrupt enable.
  - 0x10 RISE_EN, RW, per-pin rising-edge detect enable.
  - 0x14 FALL_EN, RW, per-pin falling-edge detect enable.
  - 0x18 STATUS, R/W1C, pending edge flags.
  - 0x1C DSET, WO, DOUT |= wdata; reads 0.
  - 0x20 DCLR, WO, DOUT &= ~wdata; reads 0.
  - Unmapped offsets read 0; writes to them are ignored.
- Synchroniser: chain of SYNC_STAGES flops. DIN = last stage. prev = DIN delayed by one cycle.
- Edge detect:
  - rise = DIN & ~prev & RISE_EN
  - fall = ~DIN & prev & FALL_EN
  - STATUS_next = (STATUS & ~w1c_mask) | rise | fall
- Simultaneous set and W1C on the same bit: set wins, so the bit stays 1.
- Edge detection runs regardless of DIR; an output pin looped back through the pad still flags edges.
- IRQ = |(STATUS & IRQ_EN), combinational from registers. STATUS latches even when IRQ_EN is 0, so enabling later raises IRQ immediately.
- Latency: an iData transition that is stable from edge N appears in DIN after edge N+SYNC_STAGES-1. The STATUS bit sets at edge N+SYNC_STAGES. IRQ is high in the following cycle.
- Glitches shorter than one HCLK period may be missed. No filtering is applied.
- Reset mid-transfer: the latched address-phase state is cleared and the pending write is discarded.

Decomposition:
- Package gpio_pkg holds the register offset constants (DOUT..DCLR as 4-bit indices) and the register count.
- One sub-module, gpio_sync_edge: per-vector synchroniser plus previous-sample flop. It has parameters WIDTH and SYNC_STAGES, and outputs DIN, rise_raw and fall_raw.
- Register file and AHB decode stay in the top module.

Test Plan:
- Reset then read every offset: all return 0; IRQ=0; outEn=0; oData=0.
- Write DIR=0xFF, DOUT=0xA5, DSET=0x0A, DCLR=0x80 -> oData=0x2F and outEn=0xFF; DOUT reads 0x2F; DSET and DCLR read 0.
- RISE_EN=0x01, IRQ_EN=0x01, drive iData[0] 0->1 at edge N (SYNC_STAGES=2) -> STATUS=0x01 after edge N+2; IRQ high next cycle; DIN=0x01.
- Write STATUS=0x01 in the same cycle a new rising edge sets bit 0 -> STATUS remains 0x01; a subsequent W1C with no edge -> STATUS=0x00 and IRQ=0.
- FALL_EN=0x80, IRQ_EN=0, falling edge on pin 7 -> STATUS=0x80 and IRQ=0; then write IRQ_EN=0x80 -> IRQ=1 the cycle after the write data phase.
- Back-to-back write DOUT=0x3C then read DOUT, plus a write to unmapped 0x30 -> read returns 0x3C; 0x30 reads 0; HREADYOUT stays 1 throughout; assert HRESETn low mid-write -> the write is discarded and all registers are 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// GPIO register map indices and the latched AHB address-phase record.
// Pure declarations; no logic, no latency, no flow control.
package gpio_pkg;

    localparam int REG_COUNT = 9;

    localparam logic [3:0] REG_DOUT    = 4'd0;
    localparam logic [3:0] REG_DIR     = 4'd1;
    localparam logic [3:0] REG_DIN     = 4'd2;
    localparam logic [3:0] REG_IRQ_EN  = 4'd3;
    localparam logic [3:0] REG_RISE_EN = 4'd4;
    localparam logic [3:0] REG_FALL_EN = 4'd5;
    localparam logic [3:0] REG_STATUS  = 4'd6;
    localparam logic [3:0] REG_DSET    = 4'd7;
    localparam logic [3:0] REG_DCLR    = 4'd8;

    typedef struct packed {
        logic       valid;
        logic       write;
        logic [3:0] idx;
    } aphase_t;

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser plus previous-sample flop; din lags pad by SYNC_STAGES-1 edges after capture.
// Edge outputs are raw (unmasked) and combinational from flops; no backpressure.
module gpio_sync_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise_raw,
    output logic [WIDTH-1:0] fall_raw
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]                  prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pad_in};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign din      = chain[SYNC_STAGES-1];
    assign rise_raw = din & ~prev;
    assign fall_raw = ~din & prev;

endmodule

// File: rtl/ahblite_gpio_irq.sv
// AHB-Lite GPIO with set/clear, synchronised inputs and W1C edge interrupts.
// Zero wait states (HREADYOUT tied 1); writes land one edge after the address phase.
module ahblite_gpio_irq
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic [2:0]       HSIZE,
    input  logic [3:0]       HPROT,
    input  logic             HWRITE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic             HREADYOUT,
    output logic             HRESP,
    output logic [31:0]      HRDATA,
    output logic [WIDTH-1:0] outEn,
    output logic [WIDTH-1:0] oData,
    input  logic [WIDTH-1:0] iData,
    output logic             IRQ
);

    aphase_t          ap_q;
    aphase_t          ap_next;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] irq_en_q;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] status_next;
    logic [WIDTH-1:0] w1c_mask;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] rise_raw;
    logic [WIDTH-1:0] fall_raw;
    logic             wr_en;
    logic             unused_bus_bits;

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .pad_in   (iData),
        .din      (din),
        .rise_raw (rise_raw),
        .fall_raw (fall_raw)
    );

    always_comb begin
        ap_next = '0;
        if (HSEL && HTRANS[1] && HREADY) begin
            ap_next.valid = 1'b1;
            ap_next.write = HWRITE;
            ap_next.idx   = HADDR[5:2];
        end
    end

    assign wdata    = HWDATA[WIDTH-1:0];
    assign wr_en    = ap_q.valid && ap_q.write;
    assign w1c_mask = (wr_en && ap_q.idx == REG_STATUS) ? wdata : '0;

    // A fresh edge in the same cycle as a W1C keeps the bit set.
    assign status_next = (status_q & ~w1c_mask)
                       | (rise_raw & rise_en_q)
                       | (fall_raw & fall_en_q);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            ap_q      <= '0;
            dout_q    <= '0;
            dir_q     <= '0;
            irq_en_q  <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
        end else begin
            ap_q     <= ap_next;
            status_q <= status_next;
            if (wr_en) begin
                case (ap_q.idx)
                    REG_DOUT:    dout_q    <= wdata;
                    REG_DIR:     dir_q     <= wdata;
                    REG_IRQ_EN:  irq_en_q  <= wdata;
                    REG_RISE_EN: rise_en_q <= wdata;
                    REG_FALL_EN: fall_en_q <= wdata;
                    REG_DSET:    dout_q    <= dout_q | wdata;
                    REG_DCLR:    dout_q    <= dout_q & ~wdata;
                    default:     ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (ap_q.valid && !ap_q.write) begin
            case (ap_q.idx)
                REG_DOUT:    rdata = dout_q;
                REG_DIR:     rdata = dir_q;
                REG_DIN:     rdata = din;
                REG_IRQ_EN:  rdata = irq_en_q;
                REG_RISE_EN: rdata = rise_en_q;
                REG_FALL_EN: rdata = fall_en_q;
                REG_STATUS:  rdata = status_q;
                default:     rdata = '0;
            endcase
        end
    end

    always_comb begin
        HRDATA              = '0;
        HRDATA[WIDTH-1:0]   = rdata;
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign oData     = dout_q;
    assign outEn     = dir_q;
    assign IRQ       = |(status_q & irq_en_q);

    assign unused_bus_bits = ^{HSIZE, HPROT, HADDR[31:6], HADDR[1:0], HWDATA};

endmodule

// File: tb/tb_ahblite_gpio_irq.sv
// Scoreboarded bench for ahblite_gpio_irq with WIDTH=8, SYNC_STAGES=2.
module tb_ahblite_gpio_irq;

    localparam int WIDTH = 8;

    logic             HCLK = 1'b0;
    logic             HRESETn;
    logic             HSEL;
    logic [31:0]      HADDR;
    logic [1:0]       HTRANS;
    logic [2:0]       HSIZE;
    logic [3:0]       HPROT;
    logic             HWRITE;
    logic [31:0]      HWDATA;
    logic             HREADY;
    logic             HREADYOUT;
    logic             HRESP;
    logic [31:0]      HRDATA;
    logic [WIDTH-1:0] outEn;
    logic [WIDTH-1:0] oData;
    logic [WIDTH-1:0] iData;
    logic             IRQ;

    always #5 HCLK = ~HCLK;

    ahblite_gpio_irq #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HPROT     (HPROT),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .outEn     (outEn),
        .oData     (oData),
        .iData     (iData),
        .IRQ       (IRQ)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    // Leaves the bus in the write data phase; the next edge commits it.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = a;
        HWRITE = 1'b1;
        cyc(1);
        bus_idle();
        HWDATA = d;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = a;
        HWRITE = 1'b0;
        cyc(1);
        bus_idle();
        e = sb_q.pop_front();
        check(e.tag, HRDATA, e.exp);
        check("hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("hresp", {31'd0, HRESP}, 32'd0);
    endtask

    task automatic rd_all_zero(input string tag);
        for (int i = 0; i <= 8; i++) rd(32'(i * 4), 32'h0, $sformatf("%s_off%0h", tag, i * 4));
        rd(32'h30, 32'h0, {tag, "_off30"});
    endtask

    initial begin
        HRESETn = 1'b0;
        HSEL    = 1'b0;
        HADDR   = '0;
        HTRANS  = 2'b00;
        HSIZE   = 3'b010;
        HPROT   = 4'b0011;
        HWRITE  = 1'b0;
        HWDATA  = '0;
        HREADY  = 1'b1;
        iData   = '0;

        // Reset state
        cyc(3);
        check("rst_irq", {31'd0, IRQ}, 32'd0);
        check("rst_outen", {24'd0, outEn}, 32'h0);
        check("rst_odata", {24'd0, oData}, 32'h0);
        check("rst_hrdata", HRDATA, 32'h0);
        HRESETn = 1'b1;
        cyc(1);
        rd_all_zero("rst");

        // Direction and atomic set/clear
        wr(32'h04, 32'hFF);
        wr(32'h00, 32'hA5);
        wr(32'h1C, 32'h0A);
        wr(32'h20, 32'h80);
        cyc(1);
        check("odata_setclr", {24'd0, oData}, 32'h2F);
        check("outen", {24'd0, outEn}, 32'hFF);
        rd(32'h00, 32'h2F, "dout_rd");
        rd(32'h1C, 32'h00, "dset_rd");
        rd(32'h20, 32'h00, "dclr_rd");
        rd(32'h04, 32'hFF, "dir_rd");

        // Rising-edge latency on pin 0
        wr(32'h10, 32'h01);
        wr(32'h0C, 32'h01);
        cyc(1);
        iData[0] = 1'b1;
        cyc(1);
        check("irq_n0", {31'd0, IRQ}, 32'd0);
        cyc(1);
        check("irq_n1", {31'd0, IRQ}, 32'd0);
        cyc(1);
        check("irq_n2", {31'd0, IRQ}, 32'd1);
        rd(32'h18, 32'h01, "status_rise");
        rd(32'h08, 32'h01, "din_rd");

        // W1C colliding with a new rising edge
        wr(32'h18, 32'h01);
        cyc(1);
        check("irq_w1c", {31'd0, IRQ}, 32'd0);
        iData[0] = 1'b0;
        cyc(4);
        iData[0] = 1'b1;
        cyc(1);
        wr(32'h18, 32'h01);
        cyc(1);
        rd(32'h18, 32'h01, "status_setwins");
        check("irq_setwins", {31'd0, IRQ}, 32'd1);
        wr(32'h18, 32'h01);
        rd(32'h18, 32'h00, "status_cleared");
        check("irq_cleared", {31'd0, IRQ}, 32'd0);

        // Falling edge with IRQ masked, then enable
        wr(32'h14, 32'h80);
        wr(32'h0C, 32'h00);
        cyc(1);
        iData[7] = 1'b1;
        cyc(4);
        iData[7] = 1'b0;
        cyc(4);
        check("irq_masked", {31'd0, IRQ}, 32'd0);
        rd(32'h18, 32'h80, "status_fall");
        wr(32'h0C, 32'h80);
        check("irq_pre_en", {31'd0, IRQ}, 32'd0);
        cyc(1);
        check("irq_enabled", {31'd0, IRQ}, 32'd1);

        // Back-to-back and unmapped accesses
        wr(32'h00, 32'h3C);
        rd(32'h00, 32'h3C, "b2b_dout");
        wr(32'h30, 32'h55);
        rd(32'h30, 32'h00, "unmapped_rd");
        rd(32'h00, 32'h3C, "dout_after_unmapped");
        check("odata_b2b", {24'd0, oData}, 32'h3C);

        // Reset during a write data phase
        iData = '0;
        cyc(4);
        wr(32'h00, 32'hFF);
        HRESETn = 1'b0;
        cyc(1);
        HRESETn = 1'b1;
        check("mid_odata", {24'd0, oData}, 32'h0);
        check("mid_outen", {24'd0, outEn}, 32'h0);
        check("mid_irq", {31'd0, IRQ}, 32'd0);
        cyc(1);
        check("mid_odata2", {24'd0, oData}, 32'h0);
        rd_all_zero("mid");

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
